// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: steps one full adder over WIDTH cycles, LSB first,
// keeping the carry in a register and reporting {Cout,Sum} with a one-cycle done pulse.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    // A one-bit counter is kept even for WIDTH=1 so the port of the counter never collapses.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic [WIDTH-1:0] sh_s_next;
    logic             cr;
    logic [CW-1:0]    cnt;

    logic half_s;
    logic half_c1;
    logic half_c2;
    logic fa_s;
    logic fa_c;

    // Full adder built from two half adders; sh_s_next already holds the current bit at the MSB.
    always_comb begin
        half_s    = sh_a[0] ^ sh_b[0];
        half_c1   = sh_a[0] & sh_b[0];
        fa_s      = half_s ^ cr;
        half_c2   = half_s & cr;
        fa_c      = half_c1 | half_c2;
        sh_s_next = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            sh_s_next[i] = sh_s[i + 1];
        end
        sh_s_next[WIDTH-1] = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            cr    <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= inA;
                        sh_b  <= inB;
                        cr    <= Cin;
                        sh_s  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sh_s <= sh_s_next;
                    cr   <= fa_c;
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    cnt  <= cnt + CW'(1);
                    // The last bit goes straight into the output registers.
                    if (cnt == LAST_BIT) begin
                        Sum   <= sh_s_next;
                        Cout  <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl: an 8-bit instance for word adds,
// restart/reset behaviour and throughput, plus a 1-bit instance for the full-adder table.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] inA8;
    logic [7:0] inB8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] inA1;
    logic [0:0] inB1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int passed;
    int total;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .start(start8),
        .inA  (inA8),
        .inB  (inB8),
        .Cin  (cin8),
        .busy (busy8),
        .done (done8),
        .Sum  (sum8),
        .Cout (cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .start(start1),
        .inA  (inA1),
        .inB  (inB1),
        .Cin  (cin1),
        .busy (busy1),
        .done (done1),
        .Sum  (sum1),
        .Cout (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [32:0] observed, input logic [32:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one operation on the 8-bit instance; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        inA8   = a;
        inB8   = b;
        cin8   = c;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
    endtask

    // Waits for done on the 8-bit instance, bounded; returns the number of edges taken.
    task automatic waitDone8(input string tag, output int cycles);
        cycles = 0;
        while (done8 !== 1'b1 && cycles < 30) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (done8 !== 1'b1) checkOutput({tag, "_timeout"}, 33'd0, 33'd1);
    endtask

    task automatic runAdd8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [7:0] expSum, input logic expCout);
        int cycles;
        applyStimulus(a, b, c);
        checkOutput({tag, "_busy_start"}, 33'(busy8), 33'd1);
        waitDone8(tag, cycles);
        checkOutput({tag, "_latency"}, 33'(cycles), 33'd8);
        checkOutput({tag, "_busy_at_done"}, 33'(busy8), 33'd0);
        checkOutput({tag, "_sum"}, 33'(sum8), 33'(expSum));
        checkOutput({tag, "_cout"}, 33'(cout8), 33'(expCout));
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_drop"}, 33'(done8), 33'd0);
    endtask

    initial begin
        int cycles;
        int donePulses;
        int period;
        logic [1:0] expTable [8];

        passed = 0;
        total  = 0;
        start8 = 1'b0;
        inA8   = '0;
        inB8   = '0;
        cin8   = 1'b0;
        start1 = 1'b0;
        inA1   = '0;
        inB1   = '0;
        cin1   = 1'b0;
        expTable = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 33'(busy8), 33'd0);
        checkOutput("rst_done", 33'(done8), 33'd0);
        checkOutput("rst_sum", 33'(sum8), 33'd0);
        checkOutput("rst_cout", 33'(cout8), 33'd0);
        checkOutput("rst_busy1", 33'(busy1), 33'd0);
        @(negedge clk);
        rst = 1'b0;

        runAdd8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        runAdd8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        runAdd8("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        runAdd8("5a_a5", 8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0);

        // Second start and new operands during RUN must not disturb 0x12+0x34+1 = 0x047.
        applyStimulus(8'h12, 8'h34, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1;
        inA8   = 8'hFF;
        inB8   = 8'hFF;
        cin8   = 1'b1;
        donePulses = 0;
        cycles = 0;
        while (done8 !== 1'b1 && cycles < 30) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        start8 = 1'b0;
        if (done8 === 1'b1) donePulses++;
        checkOutput("ign_latency", 33'(cycles + 3), 33'd8);
        checkOutput("ign_sum", 33'(sum8), 33'h47);
        checkOutput("ign_cout", 33'(cout8), 33'd0);
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done8 === 1'b1) donePulses++;
        end
        checkOutput("ign_done_count", 33'(donePulses), 33'd1);
        checkOutput("ign_idle_busy", 33'(busy8), 33'd0);

        // Reset in the middle of an operation abandons it and clears the held result.
        applyStimulus(8'hFF, 8'h01, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_busy", 33'(busy8), 33'd0);
        checkOutput("mid_rst_done", 33'(done8), 33'd0);
        checkOutput("mid_rst_sum", 33'(sum8), 33'd0);
        checkOutput("mid_rst_cout", 33'(cout8), 33'd0);
        @(negedge clk);
        rst = 1'b0;
        donePulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done8 === 1'b1 || busy8 === 1'b1) donePulses++;
        end
        checkOutput("mid_rst_quiet", 33'(donePulses), 33'd0);

        // start held high: operations run back to back every WIDTH+2 edges.
        @(negedge clk);
        inA8   = 8'h80;
        inB8   = 8'h80;
        cin8   = 1'b1;
        start8 = 1'b1;
        waitDone8("b2b_first", cycles);
        period = 0;
        @(posedge clk);
        #1;
        period++;
        while (done8 !== 1'b1 && period < 30) begin
            @(posedge clk);
            #1;
            period++;
        end
        start8 = 1'b0;
        checkOutput("b2b_period", 33'(period), 33'd10);
        checkOutput("b2b_sum", 33'(sum8), 33'h01);
        checkOutput("b2b_cout", 33'(cout8), 33'd1);
        repeat (3) @(posedge clk);

        // One-bit instance walks the full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            inA1   = 1'(i >> 2);
            inB1   = 1'(i >> 1);
            cin1   = 1'(i);
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            checkOutput($sformatf("w1_busy_%0d", i), 33'(busy1), 33'd1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("w1_done_%0d", i), 33'(done1), 33'd1);
            checkOutput($sformatf("w1_result_%0d", i), 33'({cout1, sum1}), 33'(expTable[i]));
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. It sequences a single one-bit full adder (two half adders plus an OR for carry-out) across WIDTH cycles to add two WIDTH-bit operands with carry-in. It captures the operands on a start handshake, feeds one bit pair per cycle LSB-first, and holds the carry between cycles in a register. It reports the WIDTH-bit sum and final carry with a one-cycle done pulse. It is the sequencing layer that lets the team's existing full-adder datapath handle multi-bit words.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- inA  input  WIDTH  operand A; captured on accepted start
- inB  input  WIDTH  operand B; captured on accepted start
- Cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when Sum/Cout become valid
- Sum  output  WIDTH  result; holds last completed value
- Cout  output  1  final carry; holds last completed value

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start=1 at an edge.
  - RUN → DONE after WIDTH bit cycles.
  - DONE → IDLE unconditionally after one cycle.
- Start acceptance (IDLE, start=1):
  - Load shA←inA and shB←inB.
  - Load carry register cr←Cin.
  - Clear the bit counter and the result shift register shS.
- Each RUN edge:
  - The full adder takes shA[0], shB[0] and cr, producing s and c.
  - shS shifts right with s inserted at MSB.
  - cr←c.
  - shA and shB shift right by one.
  - The counter increments. On the edge where counter reaches WIDTH−1 (the last bit), the state moves to DONE.
- Entry to DONE loads the output registers: Sum←final shS (including the last bit) and Cout←final carry.
- Sum and Cout change only on DONE entry and on reset. Between operations they hold the last result.
- start is ignored in RUN and DONE. It is not queued.
- inA, inB and Cin may change freely after acceptance without affecting the operation in progress.
- Arithmetic: {Cout,Sum} = inA + inB + Cin, computed modulo 2^(WIDTH+1). No overflow flag.
- Counter width: enough bits for values 0..WIDTH−1. WIDTH=1 gives exactly one RUN cycle.

## Timing
- Reset values: state=IDLE, busy=0, done=0, Sum=0, Cout=0. Internal shA, shB, shS, cr and counter are all 0.
- Reset asserted at any edge, including mid-RUN or in DONE, wins over every other transition:
  - The operation in progress is abandoned.
  - No done pulse is produced.
  - Sum and Cout are cleared.
- Start sampled at edge e0:
  - busy=1 after e0 through the edge eWIDTH.
  - At eWIDTH: busy=0, done=1, Sum and Cout valid.
  - At eWIDTH+1: done=0, state=IDLE.
- Latency: start to done is WIDTH edges after acceptance.
- The earliest next accepted start is at edge eWIDTH+2. Initiation interval is WIDTH+2 cycles.
- busy and done are never high together.
- done is high for exactly one cycle per accepted start.
- start held high continuously restarts at every IDLE, giving back-to-back operations with a WIDTH+2 period.

## Test plan
- WIDTH=8, inA=8'h00, inB=8'h00, Cin=0, start pulse → after 8 busy cycles, done pulse; Sum=8'h00, Cout=0.
- WIDTH=8, inA=8'hFF, inB=8'h01, Cin=0 → Sum=8'h00, Cout=1.
- WIDTH=8, inA=8'hFF, inB=8'hFF, Cin=1 → Sum=8'hFF, Cout=1.
- WIDTH=8, inA=8'h5A, inB=8'hA5, Cin=0 → Sum=8'hFF, Cout=0.
- WIDTH=8, second start plus changed operands applied during RUN:
  - The second start is ignored.
  - Exactly one done pulse, carrying the first operation's result.
  - Then reset asserted at bit 4 of a new operation → busy=0, done never pulses, Sum=0, Cout=0 on the next cycle.
- WIDTH=1, all 8 {inA,inB,Cin} combinations from 000 to 111 applied in sequence, each one-bit add (full-adder truth table) → {Cout,Sum} = 00, 01, 01, 10, 01, 10, 10, 11, respectively.
